// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter state type (PARITY state under UART_TX_PARITY_EN)
package uart_pkg;

  localparam int   UART_DATA_W    = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Even parity: the transmitted parity bit makes the total count of ones even.
  function automatic logic uart_even_parity(input logic [UART_DATA_W-1:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - baud counter emitting a one-cycle bit_done pulse at the last cycle of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic bit_done_o
);

  if (CLKS_PER_BIT == 1) begin : g_unit
    // Every cycle is a whole bit, so no counter is needed.
    logic unused_ok;
    assign unused_ok  = clk_i ^ rst_ni ^ clear_i;
    assign bit_done_o = 1'b1;
  end else begin : g_count
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count within the bit; wrap after the last cycle, hold at zero while cleared.
    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign bit_done_o = (cnt_q == LAST);
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: one-entry holding register, 8N1 framing, optional even parity via UART_TX_PARITY_EN
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] data,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   serial_out,
  output logic                   busy
);

  uart_tx_state_t         state_q, state_d;
  logic [UART_DATA_W-1:0] hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   serial_q, serial_d;
  logic                   load;
  logic                   bit_done;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clear_i    (state_q == IDLE),
    .bit_done_o (bit_done)
  );

  // Next state, holding-register handshake, shifting and the registered line value.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    serial_d    = UART_STOP_BIT;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    // Accept only into an empty holding register; a draining register never accepts on the same edge.
    if (data_valid && !hold_full_q) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      START: begin
        bit_cnt_d = '0;
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          // A byte waiting at the end of the stop bit starts immediately, with no idle gap.
          if (hold_full_q) load = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d     = START;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
      parity_d    = uart_even_parity(hold_q);
`endif
    end

    // The line is registered, so it is driven from the state being entered.
    case (state_d)
      START:   serial_d = UART_START_BIT;
      DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = parity_d;
`endif
      default: serial_d = UART_STOP_BIT;
    endcase
  end

  // State register; reset aborts any frame and discards the held byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      serial_q    <= UART_STOP_BIT;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      serial_q    <= serial_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign data_ready = !hold_full_q;
  assign serial_out = serial_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx at one and four clocks per bit
module tb_uart_tx;

  localparam int N0 = 1;
  localparam int N1 = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int FB  = 10;
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    int         inst;
    logic [7:0] b;
    longint     acc;
    longint     start;
    longint     fin;
  } frame_t;

  logic       clock = 1'b0;
  logic [1:0] rst_n;
  logic [1:0] vld;
  logic [7:0] din [2];
  logic       rdy [2];
  logic       ser [2];
  logic       bsy [2];

  longint cyc = 0;
  longint last_end [2];
  frame_t sb [$];
  int     n_chk = 0;
  int     n_fail = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(N0)) u_dut0 (
    .clock(clock), .reset(rst_n[0]), .data(din[0]), .data_valid(vld[0]),
    .data_ready(rdy[0]), .serial_out(ser[0]), .busy(bsy[0])
  );

  uart_tx #(.CLKS_PER_BIT(N1)) u_dut1 (
    .clock(clock), .reset(rst_n[1]), .data(din[1]), .data_valid(vld[1]),
    .data_ready(rdy[1]), .serial_out(ser[1]), .busy(bsy[1])
  );

  function automatic int nper(int i);
    return (i == 0) ? N0 : N1;
  endfunction

  // Frame bit idx: start, D0..D7 LSB first, optional even parity, stop.
  function automatic logic exp_bit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(string nm, int i, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s inst%0d cyc=%0d got=%b expected=%b", nm, i, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle compare each DUT's line, busy and ready against the frame schedule.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic eb, es, er;
      eb = 1'b0; es = 1'b1; er = 1'b1;
      if (rst_n[i]) begin
        foreach (sb[j]) begin
          if (sb[j].inst == i) begin
            if (cyc >= sb[j].start && cyc < sb[j].fin) begin
              eb = 1'b1;
              es = exp_bit(sb[j].b, int'((cyc - sb[j].start) / nper(i)));
            end
            if (cyc >= sb[j].acc && cyc < sb[j].start) er = 1'b0;
          end
        end
      end
      chk("serial_out", i, ser[i], es);
      chk("busy", i, bsy[i], eb);
      chk("data_ready", i, rdy[i], er);
    end
    for (int j = sb.size() - 1; j >= 0; j--)
      if (sb[j].fin <= cyc) sb.delete(j);
  end

  // Hold data/valid until the DUT is ready, then schedule the frame the reference model predicts.
  task automatic send(int i, logic [7:0] b);
    longint k, s;
    bit     done;
    frame_t f;
    done = 1'b0;
    din[i] = b;
    vld[i] = 1'b1;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clock);
      if (rdy[i]) begin
        k = cyc + 1;
        s = (k + 1 > last_end[i]) ? k + 1 : last_end[i];
        f.inst = i; f.b = b; f.acc = k; f.start = s; f.fin = s + FB * nper(i);
        sb.push_back(f);
        last_end[i] = f.fin;
        done = 1'b1;
        @(posedge clock); #1;
        vld[i] = 1'b0;
        din[i] = 8'($urandom);
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout inst%0d got=no_accept expected=accept", i);
      vld[i] = 1'b0;
    end
  endtask

  task automatic drop_inst(int i);
    for (int j = sb.size() - 1; j >= 0; j--)
      if (sb[j].inst == i) sb.delete(j);
    last_end[i] = 0;
  endtask

  initial begin
    longint s;
    rst_n = 2'b00;
    vld = 2'b00;
    din[0] = 8'h00; din[1] = 8'h00;
    last_end[0] = 0; last_end[1] = 0;

    // Reset held with random inputs.
    repeat (5) begin
      @(posedge clock); #1;
      vld = 2'($urandom);
      din[0] = 8'($urandom); din[1] = 8'($urandom);
    end
    for (int i = 0; i < 2; i++) begin
      chk("rst_serial", i, ser[i], 1'b1);
      chk("rst_ready", i, rdy[i], 1'b1);
      chk("rst_busy", i, bsy[i], 1'b0);
    end
    @(posedge clock); #1;
    vld = 2'b00;
    @(negedge clock); #3;
    rst_n = 2'b11;
    repeat (20) @(posedge clock);
    #1;

    // Single byte, then back-to-back 0x00/0xFF, then 0x3C presented while the holding register is full.
    send(0, 8'hA5);
    repeat (15) @(posedge clock);
    #1;
    send(0, 8'h00);
    send(0, 8'hFF);
    send(0, 8'h3C);
    send(0, 8'h07);
    send(1, 8'h01);
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge clock);
    #1;

    // Reset during D3 of a frame on the single-clock instance.
    send(0, 8'hFF);
    s = last_end[0] - FB;
    for (int t = 0; t < 100 && cyc != s + 4; t++) @(negedge clock);
    #2;
    rst_n[0] = 1'b0;
    drop_inst(0);
    #1;
    chk("midreset_serial", 0, ser[0], 1'b1);
    chk("midreset_busy", 0, bsy[0], 1'b0);
    chk("midreset_ready", 0, rdy[0], 1'b1);
    repeat (3) @(negedge clock);
    #3;
    rst_n[0] = 1'b1;
    @(posedge clock); #1;
    send(0, 8'h5A);

    // Random traffic on both instances with random gaps.
    fork
      begin
        for (int n = 0; n < 25; n++) begin
          repeat ($urandom_range(0, 15)) begin @(posedge clock); #1; end
          send(0, 8'($urandom));
        end
      end
      begin
        for (int n = 0; n < 25; n++) begin
          repeat ($urandom_range(0, 50)) begin @(posedge clock); #1; end
          send(1, 8'($urandom));
        end
      end
    join

    for (int t = 0; t < 2000 && sb.size() != 0; t++) @(posedge clock);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending expected=0", sb.size());
    end
    repeat (5) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that pairs with the existing `uart` receiver. It accepts bytes over a valid/ready handshake into a one-entry holding register and shifts each byte out on `serial_out`. Each frame is a low start bit, 8 data bits LSB first, and a high stop bit, with an optional even-parity bit. It sits between the byte-producing core logic and the serial pin. At the default `CLKS_PER_BIT = 1` it matches the receiver's one-bit-per-clock sampling.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; must be ≥1.
- `clock`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low; asserting it low clears all state immediately.
- `data`, input, 8: byte to send; sampled on an accepting edge.
- `data_valid`, input, 1: producer has a byte on `data`.
- `data_ready`, output, 1: holding register is empty.
- `serial_out`, output, 1: serial line, registered; idles high.
- `busy`, output, 1: a frame is on the line (state ≠ IDLE).

## Operation
- **Handshake:** a byte is accepted on a rising edge where `data_valid && data_ready`.
  - The byte is captured into the holding register and `hold_full` sets.
  - `data_ready = !hold_full`, taken straight from the register. No same-edge accept-while-draining.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **Transitions:**
  - IDLE → START when `hold_full`. The holding register moves into the shift register and `hold_full` clears.
  - START → DATA after 1 bit time.
  - DATA → (PARITY or STOP) after 8 bit times. The shift register shifts right once per bit.
  - PARITY → STOP after 1 bit time.
  - STOP → START if `hold_full` at the end of the stop bit (back-to-back, no idle gap); otherwise STOP → IDLE.
- **`serial_out` per state:** IDLE = 1, START = 0, DATA = `shift[0]`, PARITY = parity bit, STOP = 1.
- **Bit timing:** a bit counter (0–7) and a baud counter (0..`CLKS_PER_BIT`−1) run in START through STOP. The bit ends when the baud counter reaches `CLKS_PER_BIT`−1, then the baud counter wraps to 0. The baud counter is cleared in IDLE.
- **Overrun:** `data_valid` while `data_ready` is low is ignored. The producer must hold `data`/`data_valid`.
- **Reset mid-frame:** the frame is aborted. `serial_out` goes to 1 at once and the holding register is discarded.

## Timing
- **Reset values:** `serial_out` = 1, `data_ready` = 1, `busy` = 0; FSM in IDLE; counters 0; `hold_full` = 0.
- **Accept to start bit:** accept at edge k → START entered at edge k+1 (`serial_out` = 0 from k+1). `data_ready` is low only between k and k+1 when the FSM is idle.
- **Frame length:** 10 × `CLKS_PER_BIT` cycles, or 11 × with parity.
- **Throughput:** back-to-back frames run continuously if the next byte is accepted before the last stop-bit cycle.
- **`busy`:** rises at edge k+1 and falls at the edge that returns the FSM to IDLE.

## Configuration
- **`UART_TX_PARITY_EN` defined:** the PARITY state is compiled in. The parity bit is `^byte` (even parity), sent between D7 and the stop bit. Frame is 11 bits.
- **`UART_TX_PARITY_EN` undefined:** no PARITY state and no parity logic. Frame is 10 bits, matching the receiver.

## Structure
- **Shared package `uart_pkg`:**
  - `UART_DATA_W` = 8
  - `UART_START_BIT` = 1'b0
  - `UART_STOP_BIT` = 1'b1
  - `uart_tx_state_t` enum, with PARITY under `UART_TX_PARITY_EN`
- **Sub-module `uart_baud_tick`:** baud counter producing a one-cycle `bit_done` pulse. It takes a clear input and `CLKS_PER_BIT`, and degenerates to constant `bit_done` = 1 when `CLKS_PER_BIT` = 1.
- **`uart_tx` itself:** holding register, FSM, shift register and bit counter.

## Test plan
- **Reset:** hold `reset` low with random inputs → `serial_out` = 1, `data_ready` = 1, `busy` = 0. Release with no valid → outputs unchanged for 20 cycles.
- **Single byte:** send 0xA5 at `CLKS_PER_BIT` = 1 → from edge k+1, `serial_out` = 0,1,0,1,0,0,1,0,1,1, then stays 1. `busy` is high for exactly 10 cycles.
- **Back-to-back:** 0x00 then 0xFF, second accepted mid-frame → 20 contiguous cycles: 0, eight 0s, 1, 0, eight 1s, 1. No idle cycle between frames.
- **Slow baud:** `CLKS_PER_BIT` = 4, byte 0x01 → each bit held 4 cycles; frame is 40 cycles; D0 = 1 appears at cycles 5–8 after accept.
- **Overrun and parity:** present 0x3C while the holding register is full → not accepted until `data_ready` rises; the byte is later transmitted intact. With `UART_TX_PARITY_EN` and byte 0x07 → parity bit = 1 and frame is 11 cycles.
- **Reset mid-frame:** assert `reset` low during D3 → `serial_out` = 1 immediately, `busy` = 0. After release, the next byte 0x5A is sent as a clean frame.
